// File: rtl/sauria_cfg_seq_pkg.sv
// Shared types and constants for the SAURIA configuration AXI4-Lite sequencer.
// The optional timeout feature is enabled with SAURIA_CFG_SEQ_TIMEOUT_EN.
package sauria_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } cfg_seq_state_e;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // States in which the sequencer is waiting on the subsystem.
    function automatic logic is_wait_state(input cfg_seq_state_e st);
        return (st == ST_WR_REQ) || (st == ST_WR_RESP) ||
               (st == ST_RD_REQ) || (st == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/sauria_cfg_seq_timer.sv
// Per-transaction wait counter; expired_o pulses while enabled at LIMIT-1.
// Only instantiated when SAURIA_CFG_SEQ_TIMEOUT_EN is defined.
module sauria_cfg_seq_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sauria_cfg_axil_sequencer.sv
// Single-outstanding AXI4-Lite master for SAURIA configuration accesses.
// Define SAURIA_CFG_SEQ_TIMEOUT_EN to abort stalled transactions with SLVERR.
module sauria_cfg_axil_sequencer
    import sauria_cfg_seq_pkg::*;
#(
    parameter  int unsigned CFG_AXI_ADDR_WIDTH = 32,
    parameter  int unsigned CFG_AXI_DATA_WIDTH = 32,
    parameter  int unsigned TIMEOUT_CYCLES     = 1024,
    localparam int unsigned CFG_AXI_BYTE_NUM   = CFG_AXI_DATA_WIDTH / 8
) (
    input  logic                          i_system_clk,
    input  logic                          i_system_rst,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_write,
    input  logic [CFG_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [CFG_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [CFG_AXI_BYTE_NUM-1:0]   i_cmd_wstrb,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [CFG_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]                    o_rsp_resp,
    output logic                          o_rsp_timeout,
    output logic                          o_busy,
    output logic [CFG_AXI_ADDR_WIDTH-1:0] o_cfg_axi_awaddr,
    output logic [2:0]                    o_cfg_axi_awprot,
    output logic                          o_cfg_axi_awvalid,
    input  logic                          i_cfg_axi_awready,
    output logic [CFG_AXI_DATA_WIDTH-1:0] o_cfg_axi_wdata,
    output logic [CFG_AXI_BYTE_NUM-1:0]   o_cfg_axi_wstrb,
    output logic                          o_cfg_axi_wvalid,
    input  logic                          i_cfg_axi_wready,
    input  logic [1:0]                    i_cfg_axi_bresp,
    input  logic                          i_cfg_axi_bvalid,
    output logic                          o_cfg_axi_bready,
    output logic [CFG_AXI_ADDR_WIDTH-1:0] o_cfg_axi_araddr,
    output logic [2:0]                    o_cfg_axi_arprot,
    output logic                          o_cfg_axi_arvalid,
    input  logic                          i_cfg_axi_arready,
    input  logic [CFG_AXI_DATA_WIDTH-1:0] i_cfg_axi_rdata,
    input  logic [1:0]                    i_cfg_axi_rresp,
    input  logic                          i_cfg_axi_rvalid,
    output logic                          o_cfg_axi_rready
);

    cfg_seq_state_e                  state_q, state_d;
    logic [CFG_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CFG_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CFG_AXI_BYTE_NUM-1:0]     wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                            arvalid_q, arvalid_d, bready_q, bready_d, rready_q, rready_d;
    logic                            cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic                            rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [CFG_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic                            aw_hs_s, w_hs_s, tmo_expired_s;

    assign aw_hs_s = awvalid_q & i_cfg_axi_awready;
    assign w_hs_s  = wvalid_q & i_cfg_axi_wready;

`ifdef SAURIA_CFG_SEQ_TIMEOUT_EN
    sauria_cfg_seq_timer #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (i_system_clk),
        .rst_i     (i_system_rst),
        .clr_i     ((state_q == ST_IDLE) && i_cmd_valid),
        .en_i      (is_wait_state(state_q)),
        .expired_o (tmo_expired_s)
    );
`else
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
    assign tmo_expired_s        = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d    = i_cmd_addr;
                    wdata_d   = i_cmd_wdata;
                    wstrb_d   = i_cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (i_cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs_s;
                w_done_d  = w_done_q | w_hs_s;
                awvalid_d = ~aw_done_d;
                wvalid_d  = ~w_done_d;
                if (aw_done_d && w_done_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && i_cfg_axi_bvalid) begin
                    state_d       = ST_RSP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = i_cfg_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && i_cfg_axi_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && i_cfg_axi_rvalid) begin
                    state_d       = ST_RSP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = i_cfg_axi_rresp;
                    rsp_rdata_d   = i_cfg_axi_rdata;
                    rsp_timeout_d = 1'b0;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
        // An expired wait abandons the bus transaction and reports SLVERR.
        if (tmo_expired_s) begin
            state_d       = ST_RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = AXI_RESP_SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
        end else begin
            rsp_timeout_d = rsp_timeout_d;
        end
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_system_clk) begin
        if (i_system_rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXI_RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_cmd_ready       = cmd_ready_q;
    assign o_busy            = busy_q;
    assign o_rsp_valid       = rsp_valid_q;
    assign o_rsp_rdata       = rsp_rdata_q;
    assign o_rsp_resp        = rsp_resp_q;
    assign o_rsp_timeout     = rsp_timeout_q;
    assign o_cfg_axi_awaddr  = addr_q;
    assign o_cfg_axi_awprot  = AXI_PROT_DEFAULT;
    assign o_cfg_axi_awvalid = awvalid_q;
    assign o_cfg_axi_wdata   = wdata_q;
    assign o_cfg_axi_wstrb   = wstrb_q;
    assign o_cfg_axi_wvalid  = wvalid_q;
    assign o_cfg_axi_bready  = bready_q;
    assign o_cfg_axi_araddr  = addr_q;
    assign o_cfg_axi_arprot  = AXI_PROT_DEFAULT;
    assign o_cfg_axi_arvalid = arvalid_q;
    assign o_cfg_axi_rready  = rready_q;

endmodule

// File: tb/tb_sauria_cfg_axil_sequencer.sv
// Self-checking bench: behavioural AXI4-Lite slave with programmable delays,
// and a memory/latency reference model derived from the sequencer's rules.
module tb_sauria_cfg_axil_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    sauria_cfg_axil_sequencer #(.CFG_AXI_ADDR_WIDTH(32), .CFG_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_system_clk(clk), .i_system_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout), .o_busy(busy),
        .o_cfg_axi_awaddr(awaddr), .o_cfg_axi_awprot(awprot), .o_cfg_axi_awvalid(awvalid),
        .i_cfg_axi_awready(awready), .o_cfg_axi_wdata(wdata), .o_cfg_axi_wstrb(wstrb),
        .o_cfg_axi_wvalid(wvalid), .i_cfg_axi_wready(wready), .i_cfg_axi_bresp(bresp),
        .i_cfg_axi_bvalid(bvalid), .o_cfg_axi_bready(bready), .o_cfg_axi_araddr(araddr),
        .o_cfg_axi_arprot(arprot), .o_cfg_axi_arvalid(arvalid), .i_cfg_axi_arready(arready),
        .i_cfg_axi_rdata(rdata), .i_cfg_axi_rresp(rresp), .i_cfg_axi_rvalid(rvalid),
        .o_cfg_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Slave knobs and state
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait, b_count;
    bit aw_have, w_have, ar_have, b_hs, r_hs;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // The slave flags addresses with bit 7 set as erroring registers.
    function automatic logic [1:0] slave_resp(input logic [31:0] a);
        return a[7] ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Slave: decisions at negedge+1, so a ready/valid driven now handshakes at the next posedge.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; b_count = 0;
        aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
            end else begin
                if (b_hs) begin
                    bvalid = 0; b_hs = 0; b_count++; aw_have = 0; w_have = 0; b_wait = 0;
                end else if (aw_have && w_have && !bvalid) begin
                    if (b_wait >= b_delay) begin
                        bvalid = 1; bresp = slave_resp(s_awaddr);
                        slv_mem[s_awaddr] = merge(slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : 32'h0, s_wdata, s_wstrb);
                    end else b_wait++;
                end
                b_hs = bvalid && bready;
                awready = 0;
                if (awvalid && !aw_have) begin
                    if (aw_wait >= aw_delay) begin awready = 1; aw_have = 1; s_awaddr = awaddr; aw_wait = 0; end
                    else aw_wait++;
                end
                wready = 0;
                if (wvalid && !w_have) begin
                    if (w_wait >= w_delay) begin wready = 1; w_have = 1; s_wdata = wdata; s_wstrb = wstrb; w_wait = 0; end
                    else w_wait++;
                end
                if (r_hs) begin
                    rvalid = 0; r_hs = 0; ar_have = 0; r_wait = 0;
                end else if (ar_have && !rvalid) begin
                    if (r_wait >= r_delay) begin
                        rvalid = 1; rresp = slave_resp(s_araddr);
                        rdata = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0;
                    end else r_wait++;
                end
                r_hs = rvalid && rready;
                arready = 0;
                if (arvalid && !ar_have) begin
                    if (ar_wait >= ar_delay) begin arready = 1; ar_have = 1; s_araddr = araddr; ar_wait = 0; end
                    else ar_wait++;
                end
            end
        end
    end

    // Results of the last do_cmd
    logic [31:0] r_rdata;
    logic [1:0]  r_resp;
    logic        r_tmo, r_ok, r_stable;
    int          r_lat, r_aw_cyc, r_w_cyc, r_ar_cyc, r_acc_wait;

    task automatic set_delays(input int ad, input int wd, input int bd, input int ard, input int rd);
        aw_delay = ad; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
    endtask

    task automatic apply_reset;
        rst = 1; cmd_valid = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Issue one command from a negedge; latency counts cycles from accept (cycle 0) to rsp_valid.
    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bp);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        r_acc_wait = 0; r_ok = 1; r_stable = 1;
        r_aw_cyc = 0; r_w_cyc = 0; r_ar_cyc = 0;
        while (!cmd_ready && r_acc_wait < 50) begin @(negedge clk); r_acc_wait++; end
        if (!cmd_ready) begin r_ok = 0; cmd_valid = 0; return; end
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        r_lat = 1;
        r_aw_cyc += int'(awvalid); r_w_cyc += int'(wvalid); r_ar_cyc += int'(arvalid);
        while (!rsp_valid && r_lat < 400) begin
            @(negedge clk); r_lat++;
            r_aw_cyc += int'(awvalid); r_w_cyc += int'(wvalid); r_ar_cyc += int'(arvalid);
        end
        if (!rsp_valid) begin r_ok = 0; return; end
        r_rdata = rsp_rdata; r_resp = rsp_resp; r_tmo = rsp_timeout;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_resp !== r_resp ||
                rsp_timeout !== r_tmo || cmd_ready !== 1'b0) r_stable = 0;
        end
        rsp_ready = 1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        if ({cmd_ready, busy, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready} !== 9'b100000000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", {cmd_ready, busy, rsp_valid, rsp_timeout, awvalid, wvalid, bready, arvalid, rready}, 9'b100000000);
        end
        checks++;
        if ({rsp_rdata, rsp_resp, awaddr, araddr, awprot, arprot} !== 104'h0) begin
            failures++; $display("FAIL reset_data rdata=%h resp=%h awaddr=%h", rsp_rdata, rsp_resp, awaddr);
        end
        checks++;
    endtask

    task automatic test_write_min;
        int bc;
        set_delays(0, 0, 0, 0, 0);
        bc = b_count;
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        ref_mem[32'h10] = 32'hDEADBEEF;
        checks++; if (r_ok !== 1'b1) begin failures++; $display("FAIL wr_min_done got=%b exp=1", r_ok); end
        checks++; if (r_lat != 3) begin failures++; $display("FAIL wr_min_latency got=%0d exp=3", r_lat); end
        checks++; if (r_aw_cyc != 1 || r_w_cyc != 1) begin failures++; $display("FAIL wr_min_awwcyc got=%0d/%0d exp=1/1", r_aw_cyc, r_w_cyc); end
        checks++; if (r_resp !== 2'b00 || r_rdata !== 32'h0) begin failures++; $display("FAIL wr_min_rsp resp=%h rdata=%h exp 0/0", r_resp, r_rdata); end
        checks++; if (s_awaddr !== 32'h10 || s_wdata !== 32'hDEADBEEF || s_wstrb !== 4'hF) begin
            failures++; $display("FAIL wr_min_bus addr=%h data=%h strb=%h", s_awaddr, s_wdata, s_wstrb); end
        checks++; if (b_count != bc + 1) begin failures++; $display("FAIL wr_min_bcount got=%0d exp=%0d", b_count - bc, 1); end
    endtask

    task automatic test_read_delay;
        slv_mem[32'h20] = 32'h12345678; ref_mem[32'h20] = 32'h12345678;
        set_delays(0, 0, 0, 2, 5);
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 0);
        checks++; if (r_ok !== 1'b1 || r_rdata !== 32'h12345678 || r_resp !== 2'b00) begin
            failures++; $display("FAIL rd_delay_data ok=%b rdata=%h resp=%h exp 12345678/0", r_ok, r_rdata, r_resp); end
        checks++; if (r_ar_cyc != 3) begin failures++; $display("FAIL rd_arvalid_hold got=%0d exp=3", r_ar_cyc); end
        checks++; if (r_lat != 10) begin failures++; $display("FAIL rd_delay_latency got=%0d exp=10", r_lat); end
    endtask

    task automatic test_wr_skew;
        for (int k = 0; k < 2; k++) begin
            int bc;
            bc = b_count;
            if (k == 0) set_delays(3, 0, 1, 0, 0); else set_delays(0, 3, 1, 0, 0);
            do_cmd(1'b1, 32'h84, 32'hA5A5_0F0F, 4'h5, 0);
            ref_mem[32'h84] = merge(ref_mem.exists(32'h84) ? ref_mem[32'h84] : 32'h0, 32'hA5A5_0F0F, 4'h5);
            checks++; if (r_aw_cyc != aw_delay + 1 || r_w_cyc != w_delay + 1) begin
                failures++; $display("FAIL wr_skew%0d_valids aw=%0d w=%0d exp %0d/%0d", k, r_aw_cyc, r_w_cyc, aw_delay + 1, w_delay + 1); end
            checks++; if (r_lat != 7 || r_resp !== 2'b10 || b_count != bc + 1) begin
                failures++; $display("FAIL wr_skew%0d_rsp lat=%0d resp=%h b=%0d exp 7/2/1", k, r_lat, r_resp, b_count - bc); end
        end
    endtask

    task automatic test_backpressure;
        set_delays(0, 0, 0, 0, 0);
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 4);
        checks++; if (r_stable !== 1'b1 || r_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bp_stable stable=%b rdata=%h exp 1/deadbeef", r_stable, r_rdata); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_cmd_ready_after got=%b exp=1", cmd_ready); end
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 0);
        checks++; if (r_acc_wait != 0 || r_rdata !== 32'h12345678) begin
            failures++; $display("FAIL bp_next_cmd wait=%0d rdata=%h exp 0/12345678", r_acc_wait, r_rdata); end
    endtask

    task automatic test_random;
        slv_mem.delete(); ref_mem.delete();
        for (int t = 0; t < 30; t++) begin
            bit wr; logic [31:0] a, d, exp_rdata; logic [3:0] s; int ad, wd, bd, exp_lat;
            wr = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 7);
            d = $urandom; s = 4'($urandom_range(0, 15));
            ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            set_delays(ad, wd, bd, ad, bd);
            if (wr) begin
                exp_rdata = 32'h0; exp_lat = 3 + ((ad > wd) ? ad : wd) + bd;
                ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, s);
            end else begin
                exp_rdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0; exp_lat = 3 + ad + bd;
            end
            do_cmd(wr, a, d, s, $urandom_range(0, 2));
            checks++;
            if (r_ok !== 1'b1 || r_rdata !== exp_rdata || r_resp !== slave_resp(a) || r_tmo !== 1'b0 || r_lat != exp_lat) begin
                failures++;
                $display("FAIL rand%0d wr=%0d addr=%h rdata=%h/%h resp=%h/%h lat=%0d/%0d ok=%b",
                         t, wr, a, r_rdata, exp_rdata, r_resp, slave_resp(a), r_lat, exp_lat, r_ok);
                apply_reset();
            end
            checks++;
            if ((wr ? s_awaddr : s_araddr) !== a) begin
                failures++; $display("FAIL rand%0d_addr got=%h exp=%h", t, wr ? s_awaddr : s_araddr, a);
            end
        end
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout;
        set_delays(1000000, 0, 0, 0, 0);
`ifdef SAURIA_CFG_SEQ_TIMEOUT_EN
        do_cmd(1'b1, 32'h30, 32'h1, 4'hF, 0);
        checks++; if (r_ok !== 1'b1 || r_lat != TMO + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", r_lat, TMO + 1); end
        checks++; if (r_resp !== 2'b10 || r_tmo !== 1'b1 || r_rdata !== 32'h0) begin
            failures++; $display("FAIL tmo_rsp resp=%h tmo=%b rdata=%h exp 2/1/0", r_resp, r_tmo, r_rdata); end
`else
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        repeat (99) @(negedge clk);
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || awvalid !== 1'b1) begin
            failures++; $display("FAIL notmo_busy busy=%b rsp_valid=%b awvalid=%b exp 1/0/1", busy, rsp_valid, awvalid); end
`endif
        apply_reset();
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid;
        int n;
        bit seen;
        set_delays(0, 0, 0, 0, 1000000);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rready && n < 10) begin @(negedge clk); n++; end
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rstmid_reach_rd_data got=%b exp=1", rready); end
        rst = 1;
        @(posedge clk); @(negedge clk);
        checks++; if ({cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 8'b10000000) begin
            failures++; $display("FAIL rstmid_outputs got=%b exp=%b", {cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 8'b10000000); end
        rst = 0;
        seen = 0;
        repeat (5) begin @(negedge clk); seen |= rsp_valid; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp got=%b exp=0", seen); end
        set_delays(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        @(negedge clk);
        apply_reset();
        test_reset();
        test_write_min();
        test_read_delay();
        test_wr_skew();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        do_cmd(1'b1, 32'h8, 32'h55AA55AA, 4'hF, 0);
        checks++; if (r_ok !== 1'b1 || r_lat != 3 || r_resp !== 2'b00) begin
            failures++; $display("FAIL post_reset_write ok=%b lat=%0d resp=%h exp 1/3/0", r_ok, r_lat, r_resp); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
